// File: rtl/mem_port_arbiter.sv
// Round-robin read/write arbiter sharing one memory port, in-order read ID FIFO.
// Define ARB_STAT_EN to build per-requester handshake counters.
module mem_port_arbiter #(
  parameter int REQUESTERS      = 3,
  parameter int ADDR_WIDTH      = 16,
  parameter int DATA_WIDTH      = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                             clk,
  input  logic                             reset_p,
  input  logic [REQUESTERS*ADDR_WIDTH-1:0] s_r_addr,
  input  logic [REQUESTERS-1:0]            s_r_avalid,
  output logic [REQUESTERS-1:0]            s_r_aready,
  output logic [REQUESTERS-1:0]            s_r_dvalid,
  output logic [DATA_WIDTH-1:0]            s_r_data,
  input  logic [REQUESTERS*ADDR_WIDTH-1:0] s_w_addr,
  input  logic [REQUESTERS*DATA_WIDTH-1:0] s_w_data,
  input  logic [REQUESTERS-1:0]            s_w_valid,
  output logic [REQUESTERS-1:0]            s_w_ready,
  output logic [ADDR_WIDTH-1:0]            m_r_addr,
  output logic                             m_r_avalid,
  input  logic                             m_r_aready,
  input  logic                             m_r_dvalid,
  input  logic [DATA_WIDTH-1:0]            m_r_data,
  output logic [ADDR_WIDTH-1:0]            m_w_addr,
  output logic [DATA_WIDTH-1:0]            m_w_data,
  output logic                             m_w_valid,
  input  logic                             m_w_ready,
  output logic                             rsp_err,
  output logic [REQUESTERS*32-1:0]         stat_rd_cnt,
  output logic [REQUESTERS*32-1:0]         stat_wr_cnt
);

  localparam int PW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
  localparam int FW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  function automatic logic [PW-1:0] rr_pick(
    input logic [REQUESTERS-1:0] v,
    input logic [PW-1:0]         p
  );
    logic [PW-1:0] g;
    logic          f;
    int            j;
    g = p;
    f = 1'b0;
    for (int k = 0; k < REQUESTERS; k++) begin
      j = int'(p) + k;
      if (j >= REQUESTERS) j = j - REQUESTERS;
      if (!f && v[j]) begin
        f = 1'b1;
        g = PW'(j);
      end
    end
    return g;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (int'(p) == REQUESTERS - 1) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [FW-1:0] fptr_inc(input logic [FW-1:0] p);
    return (int'(p) == MAX_OUTSTANDING - 1) ? '0 : p + 1'b1;
  endfunction

  logic [PW-1:0] rd_ptr_q, rd_ptr_d, rd_lidx_q, rd_lidx_d, rd_gnt;
  logic          rd_lock_q, rd_lock_d, rd_hs;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, wr_lidx_q, wr_lidx_d, wr_gnt;
  logic          wr_lock_q, wr_lock_d, wr_hs;
  logic [PW-1:0] fifo_q [MAX_OUTSTANDING];
  logic [FW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          not_full, pop, err_q, err_d;

  assign not_full = cnt_q < CW'(MAX_OUTSTANDING);
  assign rd_gnt   = rd_lock_q ? rd_lidx_q : rr_pick(s_r_avalid, rd_ptr_q);
  assign wr_gnt   = wr_lock_q ? wr_lidx_q : rr_pick(s_w_valid, wr_ptr_q);

  assign m_r_avalid = !reset_p && (|s_r_avalid) && not_full;
  assign m_r_addr   = s_r_addr[int'(rd_gnt)*ADDR_WIDTH +: ADDR_WIDTH];
  assign rd_hs      = m_r_avalid && m_r_aready;

  assign m_w_valid = !reset_p && (|s_w_valid);
  assign m_w_addr  = s_w_addr[int'(wr_gnt)*ADDR_WIDTH +: ADDR_WIDTH];
  assign m_w_data  = s_w_data[int'(wr_gnt)*DATA_WIDTH +: DATA_WIDTH];
  assign wr_hs     = m_w_valid && m_w_ready;

  assign pop      = !reset_p && m_r_dvalid && (cnt_q != '0);
  assign s_r_data = m_r_data;
  assign rsp_err  = err_q;

  always_comb begin
    s_r_aready = '0;
    s_w_ready  = '0;
    s_r_dvalid = '0;
    if (!reset_p && m_r_aready && not_full) s_r_aready[rd_gnt] = 1'b1;
    if (!reset_p && m_w_ready) s_w_ready[wr_gnt] = 1'b1;
    if (pop) s_r_dvalid[fifo_q[rp_q]] = 1'b1;
  end

  // A stalled grant is locked so address and owner stay stable.
  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    rd_lock_d = rd_lock_q;
    rd_lidx_d = rd_lidx_q;
    if (rd_hs) begin
      rd_ptr_d  = ptr_inc(rd_gnt);
      rd_lock_d = 1'b0;
    end else if (m_r_avalid) begin
      rd_lock_d = 1'b1;
      rd_lidx_d = rd_gnt;
    end
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    wr_lock_d = wr_lock_q;
    wr_lidx_d = wr_lidx_q;
    if (wr_hs) begin
      wr_ptr_d  = ptr_inc(wr_gnt);
      wr_lock_d = 1'b0;
    end else if (m_w_valid) begin
      wr_lock_d = 1'b1;
      wr_lidx_d = wr_gnt;
    end
  end

  always_comb begin
    wp_d  = rd_hs ? fptr_inc(wp_q) : wp_q;
    rp_d  = pop ? fptr_inc(rp_q) : rp_q;
    cnt_d = cnt_q;
    unique case ({rd_hs, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    err_d = err_q | (m_r_dvalid && (cnt_q == '0));
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      rd_ptr_q  <= '0;
      rd_lock_q <= 1'b0;
      rd_lidx_q <= '0;
      wr_ptr_q  <= '0;
      wr_lock_q <= 1'b0;
      wr_lidx_q <= '0;
      wp_q      <= '0;
      rp_q      <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      rd_lock_q <= rd_lock_d;
      rd_lidx_q <= rd_lidx_d;
      wr_ptr_q  <= wr_ptr_d;
      wr_lock_q <= wr_lock_d;
      wr_lidx_q <= wr_lidx_d;
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_hs) fifo_q[wp_q] <= rd_gnt;
  end

`ifdef ARB_STAT_EN
  for (genvar i = 0; i < REQUESTERS; i++) begin : g_stat
    logic [31:0] rd_q, wr_q;
    always_ff @(posedge clk) begin
      if (reset_p) begin
        rd_q <= '0;
        wr_q <= '0;
      end else begin
        if (rd_hs && int'(rd_gnt) == i) rd_q <= rd_q + 1'b1;
        if (wr_hs && int'(wr_gnt) == i) wr_q <= wr_q + 1'b1;
      end
    end
    assign stat_rd_cnt[i*32 +: 32] = rd_q;
    assign stat_wr_cnt[i*32 +: 32] = wr_q;
  end
`else
  assign stat_rd_cnt = '0;
  assign stat_wr_cnt = '0;
`endif

endmodule
